// File: rtl/csr_arb_pkg.sv
// Shared types and constants for the CSR access arbiter: FSM state encoding
// and the read data returned when a slave response times out.
package csr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } arb_state_e;

  // Sliced down to the configured data width at the point of use.
  localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping modulo NUM_MST) wins; returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_MST = 2,
  parameter int IW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_MST-1:0] gnt,
  output logic [IW-1:0]      idx
);

  always_comb begin
    logic          found;
    int            cand;
    logic [IW-1:0] sel;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    sel   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_MST) cand = cand - NUM_MST;
      sel = IW'(cand);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// Shares one CSR slave port between NUM_MST masters, one transaction at a time,
// round-robin. Define CSR_ARB_TIMEOUT_EN to add the response-wait timeout.
module csr_access_arbiter
  import csr_arb_pkg::*;
#(
  parameter int NUM_MST     = 2,
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  ref_clk,
  input  logic                  sys_rstn,
  input  logic [NUM_MST-1:0]    mst_req,
  input  logic [NUM_MST-1:0]    mst_we,
  input  logic [NUM_MST*AW-1:0] mst_addr,
  input  logic [NUM_MST*DW-1:0] mst_wdata,
  output logic [NUM_MST-1:0]    mst_gnt,
  output logic [NUM_MST-1:0]    mst_rsp_vld,
  output logic [DW-1:0]         mst_rdata,
  output logic                  mst_err,
  output logic                  slv_req,
  output logic                  slv_we,
  output logic [AW-1:0]         slv_addr,
  output logic [DW-1:0]         slv_wdata,
  input  logic                  slv_ack,
  input  logic                  slv_rsp_vld,
  input  logic [DW-1:0]         slv_rdata,
  input  logic                  slv_err
);

  localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  arb_state_e         state, state_next;
  logic [IW-1:0]      rr_ptr, win_idx, arb_idx;
  logic [NUM_MST-1:0] arb_gnt;
  logic               grant_take, rsp_take, rsp_tmo;

  rr_arbiter #(.NUM_MST(NUM_MST), .IW(IW)) u_rr_arbiter (
    .req (mst_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

`ifdef CSR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts cycles spent in WAIT_RSP; zero on every entry since entry is only from ISSUE.
  always_ff @(posedge ref_clk or negedge sys_rstn) begin
    if (!sys_rstn)                tmo_cnt <= '0;
    else if (state == ST_WAIT_RSP) tmo_cnt <= tmo_cnt + TW'(1);
    else                          tmo_cnt <= '0;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ref_clk or negedge sys_rstn) begin
    if (!sys_rstn) state <= ST_IDLE;
    else           state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_take = 1'b0;
    rsp_take   = 1'b0;
    rsp_tmo    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|mst_req) begin
          grant_take = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A response arriving with the ack completes the transaction right away.
        if (slv_ack) begin
          if (slv_rsp_vld) begin
            rsp_take   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (slv_rsp_vld) begin
          rsp_take   = 1'b1;
          state_next = ST_IDLE;
        end
`ifdef CSR_ARB_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          rsp_tmo    = 1'b1;
          state_next = ST_IDLE;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign slv_req = (state == ST_ISSUE);

  always_ff @(posedge ref_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rr_ptr      <= '0;
      win_idx     <= '0;
      slv_we      <= 1'b0;
      slv_addr    <= '0;
      slv_wdata   <= '0;
      mst_gnt     <= '0;
      mst_rsp_vld <= '0;
      mst_rdata   <= '0;
      mst_err     <= 1'b0;
    end else begin
      mst_gnt     <= '0;
      mst_rsp_vld <= '0;
      if (grant_take) begin
        mst_gnt   <= arb_gnt;
        win_idx   <= arb_idx;
        slv_we    <= mst_we[arb_idx];
        slv_addr  <= mst_addr[int'(arb_idx)*AW +: AW];
        slv_wdata <= mst_wdata[int'(arb_idx)*DW +: DW];
      end
      if (rsp_take || rsp_tmo) begin
        mst_rsp_vld <= NUM_MST'(1) << win_idx;
        mst_rdata   <= rsp_tmo ? TIMEOUT_RDATA[DW-1:0] : slv_rdata;
        mst_err     <= rsp_tmo ? 1'b1 : slv_err;
        rr_ptr      <= (win_idx == IW'(NUM_MST - 1)) ? '0 : win_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Scoreboard bench for csr_access_arbiter: directed transactions push expected
// grants, slave commands and responses; a monitor pops and compares them.
module tb_csr_access_arbiter;

  localparam int NUM_MST = 2;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TMO     = 8;

  logic                  ref_clk, sys_rstn;
  logic [NUM_MST-1:0]    mst_req, mst_we, mst_gnt, mst_rsp_vld;
  logic [NUM_MST*AW-1:0] mst_addr;
  logic [NUM_MST*DW-1:0] mst_wdata;
  logic [DW-1:0]         mst_rdata, slv_wdata, slv_rdata;
  logic                  mst_err, slv_req, slv_we, slv_ack, slv_rsp_vld, slv_err;
  logic [AW-1:0]         slv_addr;

  csr_access_arbiter #(.NUM_MST(NUM_MST), .AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
    .ref_clk(ref_clk), .sys_rstn(sys_rstn),
    .mst_req(mst_req), .mst_we(mst_we), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_gnt(mst_gnt), .mst_rsp_vld(mst_rsp_vld), .mst_rdata(mst_rdata), .mst_err(mst_err),
    .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_ack(slv_ack), .slv_rsp_vld(slv_rsp_vld), .slv_rdata(slv_rdata), .slv_err(slv_err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            ack_dly;
    int            rsp_dly;
    bit            mute;
  } slv_t;

  typedef struct {
    int            mst;
    logic [DW-1:0] rdata;
    logic          err;
    bit            tmo;
  } rsp_t;

  cmd_t mq[NUM_MST][$];
  int   exp_gnt_q[$];
  rsp_t exp_rsp_q[$];
  slv_t sq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rsp_cyc = 0;
  int last_ack_cyc = 0;
  int stray_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    ref_clk = 1'b0;
    forever #5 ref_clk = ~ref_clk;
  end

  always @(posedge ref_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Master agents: present the head of each master's queue until it is granted.
  initial begin
    cmd_t tmp;
    mst_req = '0; mst_we = '0; mst_addr = '0; mst_wdata = '0;
    forever begin
      @(negedge ref_clk);
      for (int i = 0; i < NUM_MST; i++) begin
        if (mst_gnt[i] && mq[i].size() > 0) tmp = mq[i].pop_front();
        if (mq[i].size() > 0) begin
          mst_req[i]               = 1'b1;
          mst_we[i]                = mq[i][0].we;
          mst_addr[i*AW +: AW]     = mq[i][0].addr;
          mst_wdata[i*DW +: DW]    = mq[i][0].wdata;
        end else begin
          mst_req[i] = 1'b0;
        end
      end
    end
  end

  task automatic drive_rsp(input slv_t e);
    slv_rsp_vld  = 1'b1;
    slv_rdata    = e.rdata;
    slv_err      = e.err;
    last_rsp_cyc = cyc;
  endtask

  // Slave model: acks after ack_dly cycles, responds rsp_dly cycles after the ack.
  initial begin
    int   ack_cnt = 0;
    int   pend_cnt = 0;
    int   stray_seen = 0;
    bit   pend = 0;
    slv_t cur, pend_e;
    slv_ack = 1'b0; slv_rsp_vld = 1'b0; slv_rdata = '0; slv_err = 1'b0;
    forever begin
      @(negedge ref_clk);
      slv_ack     = 1'b0;
      slv_rsp_vld = 1'b0;
      if (!sys_rstn) begin
        pend    = 0;
        ack_cnt = 0;
      end else begin
        if (stray_req != stray_seen) begin
          stray_seen  = stray_req;
          slv_rsp_vld = 1'b1;
          slv_rdata   = 32'hDEAD_BEEF;
          slv_err     = 1'b1;
        end
        if (pend) begin
          if (pend_cnt == 0) begin
            drive_rsp(pend_e);
            pend = 0;
          end else pend_cnt--;
        end
        if (slv_req) begin
          if (sq.size() == 0) begin
            check("slave_unexpected_req", 64'(slv_req), 64'(0));
          end else if (ack_cnt < sq[0].ack_dly) begin
            ack_cnt++;
          end else begin
            cur          = sq.pop_front();
            ack_cnt      = 0;
            slv_ack      = 1'b1;
            last_ack_cyc = cyc;
            check("slv_we", 64'(slv_we), 64'(cur.we));
            check("slv_addr", 64'(slv_addr), 64'(cur.addr));
            if (cur.we) check("slv_wdata", 64'(slv_wdata), 64'(cur.wdata));
            if (!cur.mute) begin
              if (cur.rsp_dly == 0) drive_rsp(cur);
              else begin
                pend     = 1;
                pend_cnt = cur.rsp_dly - 1;
                pend_e   = cur;
              end
            end
          end
        end
      end
    end
  end

  // Monitor: every grant and response pulse must match the head of its queue.
  initial begin
    int   g;
    rsp_t r;
    forever begin
      @(negedge ref_clk);
      if (mst_gnt != '0) begin
        if (exp_gnt_q.size() == 0) check("unexpected_gnt", 64'(mst_gnt), 64'(0));
        else begin
          g = exp_gnt_q.pop_front();
          check("gnt", 64'(mst_gnt), 64'(1) << g);
          check("slv_req_with_gnt", 64'(slv_req), 64'(1));
        end
      end
      if (mst_rsp_vld != '0) begin
        if (exp_rsp_q.size() == 0) check("unexpected_rsp", 64'(mst_rsp_vld), 64'(0));
        else begin
          r = exp_rsp_q.pop_front();
          check("rsp_vld", 64'(mst_rsp_vld), 64'(1) << r.mst);
          check("rsp_rdata", 64'(mst_rdata), 64'(r.rdata));
          check("rsp_err", 64'(mst_err), 64'(r.err));
          if (r.tmo) check("tmo_latency", 64'(cyc), 64'(last_ack_cyc + TMO + 1));
          else       check("rsp_latency", 64'(cyc), 64'(last_rsp_cyc + 1));
          check("idle_at_rsp", 64'(slv_req), 64'(0));
        end
      end
    end
  end

  // Call in expected grant order; mute transactions are acked but never answered.
  task automatic txn(input int m, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                     input logic err, input int ack_dly, input int rsp_dly, input bit mute);
    cmd_t c;
    slv_t s;
    rsp_t r;
    c.we = we; c.addr = addr; c.wdata = wdata;
    mq[m].push_back(c);
    exp_gnt_q.push_back(m);
    s.we = we; s.addr = addr; s.wdata = wdata; s.rdata = rdata; s.err = err;
    s.ack_dly = ack_dly; s.rsp_dly = rsp_dly; s.mute = mute;
    sq.push_back(s);
    if (!mute) begin
      r.mst = m; r.rdata = rdata; r.err = err; r.tmo = 0;
      exp_rsp_q.push_back(r);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((exp_gnt_q.size() + exp_rsp_q.size() + sq.size()) != 0 && n < max_cyc) begin
      @(negedge ref_clk);
      n++;
    end
    check(name, 64'(exp_gnt_q.size() + exp_rsp_q.size() + sq.size()), 64'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_slv_req"}, 64'(slv_req), 64'(0));
    check({tag, "_slv_we"}, 64'(slv_we), 64'(0));
    check({tag, "_slv_addr"}, 64'(slv_addr), 64'(0));
    check({tag, "_slv_wdata"}, 64'(slv_wdata), 64'(0));
    check({tag, "_mst_gnt"}, 64'(mst_gnt), 64'(0));
    check({tag, "_mst_rsp_vld"}, 64'(mst_rsp_vld), 64'(0));
    check({tag, "_mst_rdata"}, 64'(mst_rdata), 64'(0));
    check({tag, "_mst_err"}, 64'(mst_err), 64'(0));
  endtask

  initial begin
    sys_rstn = 1'b0;
    repeat (3) @(negedge ref_clk);
    check_outputs_zero("reset");
    sys_rstn = 1'b1;
    @(negedge ref_clk);

    // Single read, slave acks after two wait cycles.
    txn(0, 1'b0, 16'h0010, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 1'b0);
    wait_drain("drain_single_read", 50);

    // Write from master 1 with ack and response in the same cycle.
    txn(1, 1'b1, 16'h0004, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, 0, 1'b0);
    wait_drain("drain_same_cycle_write", 50);

`ifdef CSR_ARB_TIMEOUT_EN
    begin
      rsp_t r;
      txn(0, 1'b0, 16'h0020, 32'h0, 32'h0, 1'b0, 1, 0, 1'b1);
      r.mst = 0; r.rdata = 32'hFFFF_FFFF; r.err = 1'b1; r.tmo = 1;
      exp_rsp_q.push_back(r);
      wait_drain("drain_timeout", 60);
      stray_req++;
      repeat (3) @(negedge ref_clk);
      check("late_rsp_ignored", 64'(mst_rsp_vld), 64'(0));
      check("late_rsp_rdata_hold", 64'(mst_rdata), 64'hFFFF_FFFF);
    end
`endif

    // Leaves the round-robin pointer at master 1 before the reset test.
    txn(0, 1'b0, 16'h0014, 32'h0, 32'hCAFE_0001, 1'b0, 1, 2, 1'b0);
    wait_drain("drain_ptr_setup", 50);

    // Reset while waiting for a response that never comes.
    txn(1, 1'b1, 16'h0030, 32'h5A5A_0F0F, 32'h0, 1'b0, 0, 0, 1'b1);
    wait_drain("drain_mute_ack", 50);
    repeat (3) @(negedge ref_clk);
    sys_rstn = 1'b0;
    #1;
    check_outputs_zero("mid_wait_reset");
    repeat (2) @(negedge ref_clk);
    sys_rstn = 1'b1;
    repeat (5) @(negedge ref_clk);
    check("no_rsp_after_reset", 64'(mst_rsp_vld), 64'(0));

    // Stray slave response while idle must leave the master side untouched.
    stray_req++;
    repeat (3) @(negedge ref_clk);
    check("idle_stray_rsp_vld", 64'(mst_rsp_vld), 64'(0));
    check("idle_stray_rdata", 64'(mst_rdata), 64'(0));
    check("idle_stray_err", 64'(mst_err), 64'(0));

    // Both masters request continuously: grants alternate starting at master 0.
    txn(0, 1'b0, 16'h0100, 32'h0,         32'h0000_0A00, 1'b0, 1, 1, 1'b0);
    txn(1, 1'b0, 16'h0200, 32'h0,         32'h0000_0B00, 1'b0, 0, 2, 1'b0);
    txn(0, 1'b1, 16'h0104, 32'h1111_2222, 32'h0,         1'b1, 2, 0, 1'b0);
    txn(1, 1'b0, 16'h0204, 32'h0,         32'h0000_0B04, 1'b0, 0, 0, 1'b0);
    txn(0, 1'b0, 16'h0108, 32'h0,         32'h0000_0A08, 1'b0, 1, 1, 1'b0);
    txn(1, 1'b1, 16'h0208, 32'h3333_4444, 32'h0,         1'b0, 1, 1, 1'b0);
    wait_drain("drain_contention", 200);
    repeat (3) @(negedge ref_clk);
    check("final_slv_req", 64'(slv_req), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
